vx_packet_rr_arbiter: RTL

//  N-to-1 valid/ready stream arbiter with round-robin fairness and packet locking.
//  - Once a multi-beat packet starts, the grant is held on that requester until its last beat transfers.
//  - Optional output register stage that keeps full throughput.
//  - Shares one downstream channel (memory request bus, writeback port) among cores/warps/banks.

---
 rtl/vx_packet_rr_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/vx_packet_rr_arbiter.sv
// N-to-1 valid/ready stream arbiter: round-robin between packets, grant held on a
// requester from its first beat until its last beat, optional registered output.
module vx_packet_rr_arbiter #(
  parameter int unsigned NUM_REQS     = 4,
  parameter int unsigned DATAW        = 32,
  parameter int unsigned OUT_REG      = 1,
  parameter int unsigned LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       in_valid,
  input  logic [NUM_REQS*DATAW-1:0] in_data,
  input  logic [NUM_REQS-1:0]       in_last,
  output logic [NUM_REQS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic                      out_last,
  output logic [LOG_NUM_REQS-1:0]   out_sel,
  input  logic                      out_ready,
  output logic                      locked
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [LOG_NUM_REQS-1:0] ptr_q, ptr_d;
  logic [LOG_NUM_REQS-1:0] lock_q, lock_d;

  logic [LOG_NUM_REQS-1:0] grant_idx_c;
  logic                    grant_en_c;
  logic                    grant_valid_c;
  logic                    grant_last_c;
  logic [DATAW-1:0]        grant_data_c;
  logic                    stage_ready_c;
  logic                    xfer_c;

  // Grant selection: locked requester, else first valid one from the pointer upward.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_idx_c = lock_q;
    grant_en_c  = 1'b0;
    if (state_q == S_LOCKED) begin
      grant_en_c = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NUM_REQS; k++) begin
        idx = 32'(ptr_q) + k;
        if (idx >= NUM_REQS) idx = idx - NUM_REQS;
        if (!grant_en_c && in_valid[LOG_NUM_REQS'(idx)]) begin
          grant_en_c  = 1'b1;
          grant_idx_c = LOG_NUM_REQS'(idx);
        end
      end
    end
  end

  // Payload mux of the granted requester.
  always_comb begin
    grant_valid_c = 1'b0;
    grant_last_c  = 1'b0;
    grant_data_c  = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (grant_idx_c == LOG_NUM_REQS'(i)) begin
        grant_valid_c = grant_en_c && in_valid[i];
        grant_last_c  = in_last[i];
        grant_data_c  = in_data[i*DATAW +: DATAW];
      end
    end
  end

  assign stage_ready_c = (OUT_REG != 0) ? (!out_valid || out_ready) : out_ready;
  assign xfer_c        = grant_valid_c && stage_ready_c;

  // in_ready follows the grant only, never the requester's own valid.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      in_ready[i] = grant_en_c && stage_ready_c && (grant_idx_c == LOG_NUM_REQS'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    case (state_q)
      S_IDLE: begin
        if (xfer_c && !grant_last_c) begin
          state_d = S_LOCKED;
          lock_d  = grant_idx_c;
        end
      end
      S_LOCKED: begin
        if (xfer_c && grant_last_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Pointer advances only when a packet completes.
    if (xfer_c && grant_last_c) begin
      ptr_d = (grant_idx_c == LOG_NUM_REQS'(NUM_REQS - 1)) ? '0
                                                           : grant_idx_c + LOG_NUM_REQS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

  assign locked = (state_q == S_LOCKED);

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clk) begin
      if (reset) begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_last  <= 1'b0;
        out_sel   <= '0;
      end else if (xfer_c) begin
        out_valid <= 1'b1;
        out_data  <= grant_data_c;
        out_last  <= grant_last_c;
        out_sel   <= grant_idx_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end else begin : g_out_comb
    assign out_valid = grant_valid_c;
    assign out_data  = grant_data_c;
    assign out_last  = grant_last_c;
    assign out_sel   = grant_idx_c;
  end

endmodule
